// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Purpose  : Shared timer scheduler. A single free-running prescaler produces
//            a base tick every TICK_DIV clocks. NUM_CH independent countdown
//            channels share that tick. Each channel has a programmable period
//            (in base ticks) and a one-shot/periodic mode, and emits a
//            one-cycle fire pulse on expiry.
// Ports    : clk           system clock
//            reset         synchronous active-high reset
//            enable        global run; low freezes prescaler and channel counts
//            cfg_we        write cfg_period/cfg_periodic into channel cfg_ch
//            cfg_ch        target channel of a configuration write
//            cfg_period    period in base ticks (0 = channel cannot start)
//            cfg_periodic  1 = auto-reload, 0 = one-shot
//            start[ch]     start/restart request (level, sampled each cycle)
//            stop[ch]      stop request (wins over start and tick)
//            base_tick     one-cycle pulse every TICK_DIV enabled cycles
//            fire[ch]      registered one-cycle expiry pulse
//            busy[ch]      channel is in RUN state
// Revision : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int TICK_DIV       = 250_000,
    parameter int NUM_CH         = 4,
    parameter int PERIOD_W       = 8,
    parameter int DEFAULT_PERIOD = 100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]       cfg_period,
    input  logic                      cfg_periodic,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    output logic                      base_tick,
    output logic [NUM_CH-1:0]         fire,
    output logic [NUM_CH-1:0]         busy
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int CH_W    = $clog2(NUM_CH);

    localparam logic [PRESC_W-1:0]  c_PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0] c_PERIOD_RST = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] c_ONE        = PERIOD_W'(1);

    // Channel state encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // ------------------------------------------------------------------------
    // Prescaler. base_tick is decoded combinationally from the terminal count
    // so that the channels consume the tick on the same edge that wraps the
    // prescaler; fire is then registered one cycle later.
    // ------------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc_q;
    logic [PRESC_W-1:0] w_presc_d;
    logic               w_tick;

    always_comb begin
        w_tick    = enable && (r_presc_q == c_PRESC_MAX);
        w_presc_d = r_presc_q;
        if (enable) begin
            if (w_tick) begin
                w_presc_d = '0;
            end else begin
                w_presc_d = r_presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q <= '0;
        end else begin
            r_presc_q <= w_presc_d;
        end
    end

    assign base_tick = w_tick;

    // ------------------------------------------------------------------------
    // Countdown channels
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [0:0]          r_state_q;
        logic [0:0]          w_state_d;
        logic [PERIOD_W-1:0] r_rem_q;
        logic [PERIOD_W-1:0] w_rem_d;
        logic [PERIOD_W-1:0] r_period_q;
        logic [PERIOD_W-1:0] w_period_d;
        logic                r_periodic_q;
        logic                w_periodic_d;
        logic                r_fire_q;
        logic                w_fire_d;
        logic                w_cfg_hit;

        // An out-of-range cfg_ch simply matches no channel.
        assign w_cfg_hit = cfg_we && (cfg_ch == CH_W'(ch));

        always_comb begin
            // Configuration registers. The "_d" values are the effective
            // configuration: a write in the same cycle as a start or reload
            // is already visible to it.
            w_period_d   = r_period_q;
            w_periodic_d = r_periodic_q;
            if (w_cfg_hit) begin
                w_period_d   = cfg_period;
                w_periodic_d = cfg_periodic;
            end

            w_state_d = r_state_q;
            w_rem_d   = r_rem_q;
            w_fire_d  = 1'b0;

            if (stop[ch]) begin
                // Stop dominates; a coincident tick or start is discarded.
                w_state_d = c_IDLE;
                w_rem_d   = '0;
            end else if (start[ch] && (w_period_d != '0)) begin
                // (Re)load; a coincident tick is not counted. A start with a
                // zero effective period falls through and leaves the channel
                // untouched apart from tick handling below being skipped.
                w_state_d = c_RUN;
                w_rem_d   = w_period_d;
            end else if (start[ch]) begin
                // Zero-period start: ignored entirely, including the tick.
                w_state_d = r_state_q;
            end else if (w_tick && (r_state_q == c_RUN)) begin
                if (r_rem_q > c_ONE) begin
                    w_rem_d = r_rem_q - c_ONE;
                end else begin
                    // Final count consumed. A periodic channel whose period
                    // was rewritten to 0 stops here instead of reloading.
                    w_fire_d = 1'b1;
                    if (w_periodic_d && (w_period_d != '0)) begin
                        w_rem_d = w_period_d;
                    end else begin
                        w_state_d = c_IDLE;
                        w_rem_d   = '0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state_q    <= c_IDLE;
                r_rem_q      <= '0;
                r_period_q   <= c_PERIOD_RST;
                r_periodic_q <= 1'b0;
                r_fire_q     <= 1'b0;
            end else begin
                r_state_q    <= w_state_d;
                r_rem_q      <= w_rem_d;
                r_period_q   <= w_period_d;
                r_periodic_q <= w_periodic_d;
                r_fire_q     <= w_fire_d;
            end
        end

        assign fire[ch] = r_fire_q;
        assign busy[ch] = (r_state_q == c_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tick_scheduler
// Purpose  : Directed self-checking bench for tick_scheduler with TICK_DIV=4.
//            Latencies are counted in clock edges after the start cycle; with
//            the start applied on the edge right after a tick (prescaler 0),
//            fire becomes visible 4*P-1 edges later for a period of P.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int TICK_DIV       = 4;
    localparam int NUM_CH         = 4;
    localparam int PERIOD_W       = 8;
    localparam int DEFAULT_PERIOD = 100;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                cfg_we;
    logic [1:0]          cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_periodic;
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   stop;
    wire                 base_tick;
    wire  [NUM_CH-1:0]   fire;
    wire  [NUM_CH-1:0]   busy;

    int checks = 0;
    int errors = 0;

    tick_scheduler #(
        .TICK_DIV      (TICK_DIV),
        .NUM_CH        (NUM_CH),
        .PERIOD_W      (PERIOD_W),
        .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_periodic(cfg_periodic),
        .start       (start),
        .stop        (stop),
        .base_tick   (base_tick),
        .fire        (fire),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land at the sampling point just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int p, input logic per);
        logic [31:0] v_ch;
        logic [31:0] v_p;
        v_ch         = ch;
        v_p          = p;
        cfg_we       = 1'b1;
        cfg_ch       = v_ch[1:0];
        cfg_period   = v_p[PERIOD_W-1:0];
        cfg_periodic = per;
        step();
        cfg_we       = 1'b0;
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] mask);
        start = mask;
        step();
        start = '0;
    endtask

    // Wait for a tick-pending sample point, then pass that edge so the
    // prescaler sits at 0 for the next driven edge.
    task automatic align();
        int k;
        k = 0;
        while (base_tick !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        check("align_tick", base_tick, 1);
        step();
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (base_tick !== 1'b1 && k < 8) begin
            step();
            k++;
        end
    endtask

    task automatic wait_fire(input int ch, input int limit, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < limit) begin
            step();
            i++;
            if (fire[ch] === 1'b1) n = i;
        end
    endtask

    task automatic run(input int ncyc, input int ch, output int nfire, output int ntick);
        nfire = 0;
        ntick = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (fire[ch] === 1'b1) nfire++;
            if (base_tick === 1'b1) ntick++;
        end
    endtask

    initial begin
        int n;
        int nf;
        int nt;

        reset        = 1'b1;
        enable       = 1'b1;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_period   = '0;
        cfg_periodic = 1'b0;
        start        = '0;
        stop         = '0;

        repeat (3) step();
        check("rst_base_tick", base_tick, 0);
        check("rst_fire", fire, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // ---- base_tick cadence ----
        wait_tick();
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (base_tick !== 1'b1 && n < 10);
            check("cadence", n, TICK_DIV);
        end

        // ---- basic one-shot, period 3 ----
        cfg(0, 3, 1'b0);
        align();
        do_start(4'b0001);
        check("os_busy_start", busy[0], 1);
        wait_fire(0, 40, n);
        check("os_latency", n, 11);
        check("os_busy_at_fire", busy[0], 0);
        run(20, 0, nf, nt);
        check("os_no_refire", nf, 0);
        check("os_tick_count", nt, 5);

        // ---- periodic, period 2, five periods then stop ----
        cfg(1, 2, 1'b1);
        align();
        do_start(4'b0010);
        wait_fire(1, 40, n);
        check("per_first", n, 7);
        for (int r = 0; r < 4; r++) begin
            wait_fire(1, 40, n);
            check("per_spacing", n, 8);
        end
        check("per_busy_run", busy[1], 1);
        repeat (3) step();
        stop = 4'b0010;
        step();
        stop = '0;
        check("per_busy_after_stop", busy[1], 0);
        run(20, 1, nf, nt);
        check("per_no_fire_after_stop", nf, 0);

        // ---- stop+start coincident with a tick ----
        cfg(2, 2, 1'b0);
        align();
        do_start(4'b0100);
        wait_tick();
        stop  = 4'b0100;
        start = 4'b0100;
        step();
        stop  = '0;
        start = '0;
        check("ss_busy", busy[2], 0);
        run(20, 2, nf, nt);
        check("ss_no_fire", nf, 0);

        // ---- start coincident with a tick: that tick is not counted ----
        wait_tick();
        do_start(4'b0100);
        wait_fire(2, 40, n);
        check("start_on_tick_latency", n, 8);

        // ---- period rewrite while running periodic ----
        cfg(0, 3, 1'b1);
        align();
        do_start(4'b0001);
        cfg(0, 5, 1'b1);
        wait_fire(0, 40, n);
        check("rewrite_current", n, 10);
        wait_fire(0, 40, n);
        check("rewrite_reload", n, 20);
        stop = 4'b0001;
        step();
        stop = '0;
        check("rewrite_stop_busy", busy[0], 0);

        // ---- cfg_we and start in the same cycle ----
        align();
        cfg_we       = 1'b1;
        cfg_ch       = 2'd3;
        cfg_period   = 8'd2;
        cfg_periodic = 1'b0;
        start        = 4'b1000;
        step();
        cfg_we = 1'b0;
        start  = '0;
        wait_fire(3, 40, n);
        check("cfg_start_same", n, 7);

        // ---- start with period 0 ----
        cfg(3, 0, 1'b0);
        do_start(4'b1000);
        check("p0_busy", busy[3], 0);
        run(12, 3, nf, nt);
        check("p0_no_fire", nf, 0);
        check("p0_busy_later", busy[3], 0);

        // ---- period 0 written to a running periodic channel ----
        cfg(1, 2, 1'b1);
        align();
        do_start(4'b0010);
        cfg(1, 0, 1'b1);
        wait_fire(1, 40, n);
        check("p0_periodic_fire", n, 6);
        check("p0_periodic_idle", busy[1], 0);
        run(20, 1, nf, nt);
        check("p0_periodic_no_refire", nf, 0);

        // ---- simultaneous fire on two channels ----
        cfg(1, 2, 1'b0);
        cfg(2, 2, 1'b0);
        align();
        do_start(4'b0110);
        wait_fire(1, 40, n);
        check("multi_latency", n, 7);
        check("multi_fire_vec", fire, 4'b0110);

        // ---- enable low for 20 cycles mid-count ----
        cfg(0, 3, 1'b0);
        align();
        do_start(4'b0001);
        step();
        enable = 1'b0;
        run(20, 0, nf, nt);
        check("en_no_tick", nt, 0);
        check("en_no_fire", nf, 0);
        check("en_busy_held", busy[0], 1);
        enable = 1'b1;
        wait_fire(0, 60, n);
        check("en_delayed_fire", n, 10);

        // ---- reset with all channels running and a fire due ----
        cfg(3, 2, 1'b0);
        align();
        do_start(4'b1111);
        repeat (6) step();
        check("rst_pre_busy", busy, 4'b1111);
        check("rst_pre_tick", base_tick, 1);
        reset = 1'b1;
        step();
        check("rst_mid_fire", fire, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tick", base_tick, 0);
        reset = 1'b0;
        step();
        check("rst_post_fire", fire, 0);

        // ---- default period after reset ----
        align();
        do_start(4'b0001);
        check("dflt_busy", busy[0], 1);
        wait_fire(0, 450, n);
        check("dflt_latency", n, 4 * DEFAULT_PERIOD - 1);
        check("dflt_oneshot_idle", busy[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
